i2s_serializer: RTL and testbench

I2S_SERIALIZER -- requirements
Module: i2s_serializer

---
 rtl/i2s_serializer.sv | 135 +++++++++++++
 tb/tb_i2s_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serializer.sv
// Left-justified I2S transmitter with a 2-word sample FIFO.
// One 64-bit frame carries {left, 8'h00, right, 8'h00}, MSB first.
module i2s_serializer #(
    parameter int SCK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_in,
    input  logic        tick_in,
    input  logic [23:0] audio0_in,
    input  logic [23:0] audio1_in,
    output logic        req_out,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sdo_out,
    output logic        overrun_out,
    output logic        underrun_out
);

    localparam logic [0:0] STOP = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;
    localparam logic [7:0] DIV_MAX = 8'(SCK_DIV - 1);

    logic [0:0]  state;
    logic [47:0] mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [63:0] sr;

    logic        full;
    logic        empty;
    logic [47:0] head;
    logic [63:0] frame_word;
    logic        div_wrap;
    logic        fall;
    logic        boundary;
    logic        load;
    logic        stop_now;
    logic        pop;
    logic        push;
    logic        wr_en;
    logic        wr_idx;

    always_comb begin
        full       = (count == 2'd2);
        empty      = (count == 2'd0);
        head       = mem[rd_ptr];
        div_wrap   = (state == PLAY) && (div_cnt == DIV_MAX);
        fall       = div_wrap && sck_out;
        boundary   = fall && (bit_cnt == 6'd63);
        load       = play_in && ((state == STOP) || boundary);
        stop_now   = boundary && !play_in;
        pop        = load && !empty;
        push       = tick_in && (!full || pop);
        wr_en      = stop_now ? tick_in : push;
        wr_idx     = stop_now ? 1'b0 : wr_ptr;
        frame_word = 64'h0;
        if (pop)
            frame_word = {head[47:24], 8'h00, head[23:0], 8'h00};
    end

    // Storage only; occupancy and pointers carry validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem[wr_idx] <= {audio0_in, audio1_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (stop_now) begin
            rd_ptr <= 1'b0;
            wr_ptr <= tick_in;
            count  <= {1'b0, tick_in};
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_out      <= 1'b0;
            overrun_out  <= 1'b0;
            underrun_out <= 1'b0;
        end else begin
            req_out      <= pop;
            overrun_out  <= tick_in && full && !pop && !stop_now;
            underrun_out <= load && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STOP;
            div_cnt <= 8'd0;
            bit_cnt <= 6'd0;
            sck_out <= 1'b0;
            sr      <= 64'h0;
        end else if (state == STOP) begin
            div_cnt <= 8'd0;
            bit_cnt <= 6'd0;
            sck_out <= 1'b0;
            sr      <= frame_word;
            if (play_in)
                state <= PLAY;
        end else if (stop_now) begin
            state   <= STOP;
            div_cnt <= 8'd0;
            bit_cnt <= 6'd0;
            sck_out <= 1'b0;
            sr      <= 64'h0;
        end else begin
            div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
            if (div_wrap)
                sck_out <= ~sck_out;
            if (fall) begin
                bit_cnt <= bit_cnt + 6'd1;
                sr      <= boundary ? frame_word : {sr[62:0], 1'b0};
            end
        end
    end

    assign ws_out  = bit_cnt[5];
    assign sdo_out = sr[63];

endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer: directed scenarios then random traffic,
// compared each cycle against a frame-timing reference model.
module tb_i2s_serializer;

    localparam int D  = 4;
    localparam int FR = 128 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play_in = 1'b0;
    logic        tick_in = 1'b0;
    logic [23:0] a0 = 24'h0;
    logic [23:0] a1 = 24'h0;
    logic        req_out;
    logic        sck_out;
    logic        ws_out;
    logic        sdo_out;
    logic        overrun_out;
    logic        underrun_out;

    always #5 clk = ~clk;

    i2s_serializer #(.SCK_DIV(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .play_in      (play_in),
        .tick_in      (tick_in),
        .audio0_in    (a0),
        .audio1_in    (a1),
        .req_out      (req_out),
        .sck_out      (sck_out),
        .ws_out       (ws_out),
        .sdo_out      (sdo_out),
        .overrun_out  (overrun_out),
        .underrun_out (underrun_out)
    );

    int errors = 0;
    int checks = 0;

    logic [47:0] q [$];
    bit          playing = 0;
    int          k = 0;
    logic [63:0] w = 64'h0;
    logic        e_req = 1'b0;
    logic        e_ovr = 1'b0;
    logic        e_und = 1'b0;
    logic        prev_sck = 1'b0;
    logic [63:0] cap = 64'h0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b k=%0d", tag, obs, exp, k);
        end
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model();
        bit          load;
        bit          stp;
        logic [47:0] e;
        load  = 0;
        stp   = 0;
        e_req = 1'b0;
        e_ovr = 1'b0;
        e_und = 1'b0;
        if (rst) begin
            q.delete();
            playing = 0;
            k = 0;
            return;
        end
        if (!playing) begin
            if (play_in) begin
                load = 1;
                playing = 1;
                k = 0;
            end
        end else begin
            k++;
            if (k == FR) begin
                k = 0;
                if (play_in) load = 1;
                else stp = 1;
            end
        end
        if (load) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                w = {e[47:24], 8'h00, e[23:0], 8'h00};
                e_req = 1'b1;
            end else begin
                w = 64'h0;
                e_und = 1'b1;
            end
        end
        if (stp) begin
            playing = 0;
            k = 0;
            q.delete();
            if (tick_in) q.push_back({a0, a1});
        end else if (tick_in) begin
            if (q.size() < 2) q.push_back({a0, a1});
            else e_ovr = 1'b1;
        end
    endtask

    task automatic step();
        int   b;
        logic es;
        @(posedge clk);
        model();
        @(negedge clk);
        b  = k / (2 * D);
        es = playing ? logic'((k / D) % 2) : 1'b0;
        chk("sck", sck_out, es);
        chk("ws", ws_out, playing && (b >= 32));
        chk("sdo", sdo_out, playing ? w[63 - b] : 1'b0);
        chk("req", req_out, e_req);
        chk("overrun", overrun_out, e_ovr);
        chk("underrun", underrun_out, e_und);
        chkv("fifo_count", 64'(dut.count), 64'(q.size()));
        if (!prev_sck && sck_out)
            cap = {cap[62:0], sdo_out};
        prev_sck = sck_out;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic tick1(input logic [23:0] l, input logic [23:0] r);
        a0 = l;
        a1 = r;
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
    endtask

    task automatic rnd_tick();
        tick1(24'($urandom), 24'($urandom));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        tick_in = 1'b1;
        play_in = 1'b1;
        step();
        tick_in = 1'b0;
        play_in = 1'b0;
        step();
        rst = 1'b0;
        run(3);

        tick1(24'hA5A5A5, 24'h5A5A5A);
        cap = 64'h0;
        play_in = 1'b1;
        step();
        play_in = 1'b0;
        run(FR);
        chkv("frame_bits", cap, 64'hA5A5A5005A5A5A00);
        run(5);

        play_in = 1'b1;
        run(2);
        play_in = 1'b0;
        run(FR + 4);

        rnd_tick();
        rnd_tick();
        rnd_tick();
        play_in = 1'b1;
        run(2 * FR + 10);
        play_in = 1'b0;
        run(FR + 4);

        rnd_tick();
        play_in = 1'b1;
        step();
        run(10 * 2 * D + 2);
        play_in = 1'b0;
        run(FR);
        chkv("flushed", 64'(dut.count), 64'd0);

        rnd_tick();
        play_in = 1'b1;
        step();
        run(40 * 2 * D + 3);
        rst = 1'b1;
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        rst = 1'b0;
        run(3 * D);
        rnd_tick();

        rnd_tick();
        rnd_tick();
        n = 0;
        while (!(playing && k == FR - 1) && n < 2 * FR) begin
            step();
            n++;
        end
        chk("boundary_reached", playing && (k == FR - 1), 1'b1);
        rnd_tick();
        chkv("full_pop_count", 64'(dut.count), 64'd2);
        run(FR);
        play_in = 1'b0;
        run(FR + 4);

        for (int i = 0; i < 8000; i++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 699) == 0)
                play_in = ~play_in;
            tick_in = ($urandom_range(0, 249) == 0);
            a0 = 24'($urandom);
            a1 = 24'($urandom);
            step();
        end
        rst = 1'b0;
        tick_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
